// File: rtl/acc_requant_drain_pkg.sv
// Shared widths, limits and drain FSM states for the accumulator
// requantize/drain block.
package acc_requant_drain_pkg;

    localparam int ACC_W     = 32;
    localparam int OUT_W     = 8;
    localparam int PROD_W    = 49;
    localparam int MAX_SHIFT = 47;
    localparam int MULT_W    = 16;
    localparam int SHIFT_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/acc_requant_drain_core.sv
// Combinational round-half-up shift, zero-point offset and int8 saturation.
// REQUANT_RELU_EN raises the lower clamp to zero_point (fused ReLU).
module requant_core
    import acc_requant_drain_pkg::*;
(
    input  logic signed [PROD_W-1:0]  p,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic signed [OUT_W-1:0]   zero_point,
    output logic signed [OUT_W-1:0]   y
);

    localparam int RW = PROD_W + 1;
    localparam int SW = RW + 1;

    logic        [SHIFT_W-1:0] sh;
    logic signed [RW-1:0]      bias;
    logic signed [RW-1:0]      r;
    logic signed [SW-1:0]      sum;
    logic signed [SW-1:0]      lo;
    logic signed [SW-1:0]      hi;

    always_comb begin
        sh = (shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift;
        bias = '0;
        if (sh != '0) begin
            bias[sh - 1'b1] = 1'b1;
        end
        // One extra bit keeps p + bias from wrapping at the product extremes.
        r   = (RW'(p) + bias) >>> sh;
        sum = SW'(r) + SW'(zero_point);
        hi  = SW'(2 ** (OUT_W - 1) - 1);
`ifdef REQUANT_RELU_EN
        lo  = SW'(zero_point);
`else
        lo  = SW'(-(2 ** (OUT_W - 1)));
`endif
        if (sum > hi) begin
            y = hi[OUT_W-1:0];
        end else if (sum < lo) begin
            y = lo[OUT_W-1:0];
        end else begin
            y = sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/acc_requant_drain.sv
// Snapshots the PE accumulator array, clears it, and streams requantized
// int8 elements row-major over a valid/ready port. Option: REQUANT_RELU_EN.
module acc_requant_drain
    import acc_requant_drain_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ROWS*COLS*ACC_W-1:0]  acc_flat,
    input  logic [MULT_W-1:0]           mult,
    input  logic [SHIFT_W-1:0]          shift,
    input  logic [OUT_W-1:0]            zero_point,
    output logic                        accum_clear,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] N_I    = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N - 1);

    state_t state_q, state_d;

    logic [N*ACC_W-1:0]   snap_q, snap_d;
    logic [MULT_W-1:0]    mult_q, mult_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [OUT_W-1:0]     zp_q, zp_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;
    logic [PROD_W-1:0]    p_q, p_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 out_last_q, out_last_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;

    logic signed [ACC_W-1:0]  cur_acc;
    logic        [MULT_W-1:0] cur_mult;
    logic signed [OUT_W-1:0]  y;
    logic                     s2_take;
    logic                     s1_free;
    logic                     issue;
    logic                     xfer;

    requant_core u_core (
        .p          (p_q),
        .shift      (shift_q),
        .zero_point (zp_q),
        .y          (y)
    );

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        mult_d     = mult_q;
        shift_d    = shift_q;
        zp_d       = zp_q;
        idx_d      = idx_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        p_d        = p_q;
        s2_valid_d = s2_valid_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;

        // Element 0 is issued straight from the live inputs during CAPTURE
        // so the first result appears two cycles after the snapshot.
        if (state_q == CAPTURE) begin
            cur_acc  = acc_flat[ACC_W-1:0];
            cur_mult = mult;
        end else begin
            cur_acc  = snap_q[int'(idx_q)*ACC_W +: ACC_W];
            cur_mult = mult_q;
        end

        xfer    = s2_valid_q && out_ready;
        s2_take = !s2_valid_q || out_ready;
        s1_free = !s1_valid_q || s2_take;
        issue   = s1_free &&
                  ((state_q == CAPTURE) ||
                   ((state_q == DRAIN) && (idx_q < N_I)));

        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            out_last_d = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_data_d = y;
            end
        end

        if (issue) begin
            s1_valid_d = 1'b1;
            s1_last_d  = (idx_q == LAST_I);
            p_d        = PROD_W'(cur_acc) *
                         PROD_W'($signed({1'b0, cur_mult}));
            idx_d      = idx_q + 1'b1;
        end else if (s1_valid_q && s2_take) begin
            s1_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                end
            end
            CAPTURE: begin
                snap_d  = acc_flat;
                mult_d  = mult;
                shift_d = shift;
                zp_d    = zero_point;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (xfer && out_last_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            mult_q     <= '0;
            shift_q    <= '0;
            zp_q       <= '0;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            p_q        <= '0;
            s2_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            mult_q     <= mult_d;
            shift_q    <= shift_d;
            zp_q       <= zp_d;
            idx_q      <= idx_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            p_q        <= p_d;
            s2_valid_q <= s2_valid_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
        end
    end

    assign accum_clear = (state_q == CAPTURE);
    assign done        = (state_q == FINISH);
    assign busy        = (state_q != IDLE);
    assign out_valid   = s2_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_acc_requant_drain.sv
// Directed bench for acc_requant_drain: a 4x4 and a 2x2 instance.
// Define REQUANT_RELU_EN consistently for RTL and bench.
module tb_acc_requant_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         start4, clr4, ov4, rdy4, ol4, busy4, done4;
    logic [511:0] acc4;
    logic [15:0]  mult4;
    logic [5:0]   shift4;
    logic [7:0]   zp4, od4;

    logic         start2, clr2, ov2, rdy2, ol2, busy2, done2;
    logic [127:0] acc2;
    logic [15:0]  mult2;
    logic [5:0]   shift2;
    logic [7:0]   zp2, od2;

    int total = 0;
    int bad   = 0;

    logic signed [7:0] q2_d[4];
    logic              q2_l[4];
    int                n2;
    logic signed [7:0] q4_d[16];
    logic              q4_l[16];
    int                n4;

    acc_requant_drain #(.ROWS(4), .COLS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .acc_flat(acc4),
        .mult(mult4), .shift(shift4), .zero_point(zp4),
        .accum_clear(clr4), .out_data(od4), .out_valid(ov4),
        .out_ready(rdy4), .out_last(ol4), .busy(busy4), .done(done4)
    );

    acc_requant_drain #(.ROWS(2), .COLS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .acc_flat(acc2),
        .mult(mult2), .shift(shift2), .zero_point(zp2),
        .accum_clear(clr2), .out_data(od2), .out_valid(ov2),
        .out_ready(rdy2), .out_last(ol2), .busy(busy2), .done(done2)
    );

    function automatic logic signed [7:0] ref_q(input int acc, input int m,
                                                input int sh, input int zp);
        longint p, r, y, lo;
        p = longint'(acc) * longint'(m);
        if (sh > 47) sh = 47;
        if (sh == 0) r = p;
        else r = (p + (longint'(1) << (sh - 1))) >>> sh;
        y  = r + longint'(zp);
        lo = -128;
`ifdef REQUANT_RELU_EN
        lo = longint'(zp);
`endif
        if (y > 127) y = 127;
        if (y < lo) y = lo;
        return 8'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain2(input logic [127:0] acc, input logic [15:0] m,
                          input logic [5:0] sh, input logic [7:0] zp);
        acc2 = acc; mult2 = m; shift2 = sh; zp2 = zp; rdy2 = 1'b1;
        n2 = 0;
        tick(); start2 = 1'b1;
        tick(); start2 = 1'b0;
        for (int c = 0; c < 40 && n2 < 4; c++) begin
            if (ov2) begin
                q2_d[n2] = od2; q2_l[n2] = ol2; n2++;
            end
            tick();
        end
    endtask

    task automatic drain4();
        rdy4 = 1'b1;
        n4 = 0;
        tick(); start4 = 1'b1;
        tick(); start4 = 1'b0;
        for (int c = 0; c < 80 && n4 < 16; c++) begin
            if (ov4) begin
                q4_d[n4] = od4; q4_l[n4] = ol4; n4++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b1; start2 = 1'b1;
        rdy4 = 1'b1; rdy2 = 1'b1;
        acc4 = '0; acc2 = '0;
        mult4 = 16'd1; mult2 = 16'd1; shift4 = '0; shift2 = '0;
        zp4 = '0; zp2 = '0;
        tick(); tick(); tick();
        total++;
        if ({busy4, ov4, ol4, done4, clr4} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl4 got=%b exp=00000",
                     {busy4, ov4, ol4, done4, clr4});
        end
        total++;
        if (od4 !== 8'd0) begin
            bad++; $display("FAIL reset_data4 got=%0d exp=0", od4);
        end
        total++;
        if ({busy2, ov2, ol2, done2, clr2, od2} !== 13'b0) begin
            bad++;
            $display("FAIL reset_all2 got=%b exp=0",
                     {busy2, ov2, ol2, done2, clr2, od2});
        end
        rst = 1'b0; start4 = 1'b0; start2 = 1'b0;
        tick();
        total++;
        if (busy4 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL start_with_rst busy4=%b busy2=%b exp=0",
                     busy4, busy2);
        end
    endtask

    task automatic test_timing_2x2();
        logic signed [7:0] exp_d[4];
        int cyc;
        exp_d = '{8'sd25, -8'sd25, 8'sd127, 8'sd0};
        acc2 = {32'sd0, 32'sd1000, -32'sd100, 32'sd100};
        mult2 = 16'd1; shift2 = 6'd2; zp2 = 8'd0; rdy2 = 1'b1;
        n2 = 0;
        tick(); start2 = 1'b1;
        tick(); start2 = 1'b0;
        total++;
        if (clr2 !== 1'b1 || busy2 !== 1'b1 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL cycle1 clr=%b busy=%b ov=%b exp=1,1,0",
                     clr2, busy2, ov2);
        end
        tick();
        total++;
        if (clr2 !== 1'b0 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL cycle2 clr=%b ov=%b exp=0,0", clr2, ov2);
        end
        tick();
        total++;
        if (ov2 !== 1'b1) begin
            bad++; $display("FAIL cycle3_valid got=%b exp=1", ov2);
        end
        cyc = 0;
        for (int c = 0; c < 20 && n2 < 4; c++) begin
            if (ov2) begin
                q2_d[n2] = od2; q2_l[n2] = ol2; n2++;
            end
            if (n2 == 2) start2 = 1'b1;
            cyc++;
            tick();
            start2 = 1'b0;
        end
        total++;
        if (n2 !== 4 || cyc !== 4) begin
            bad++;
            $display("FAIL drain2_count got=%0d in %0d cycles exp=4 in 4",
                     n2, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q2_d[i] !== exp_d[i] || q2_l[i] !== (i == 3)) begin
                bad++;
                $display("FAIL drain2_el%0d got=%0d/%b exp=%0d/%b",
                         i, q2_d[i], q2_l[i], exp_d[i], (i == 3));
            end
        end
        total++;
        if (done2 !== 1'b1 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse done=%b ov=%b exp=1,0", done2, ov2);
        end
        tick();
        total++;
        if (done2 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL done_end done=%b busy=%b exp=0,0", done2, busy2);
        end
        tick();
        total++;
        if (busy2 !== 1'b0 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL start_while_busy busy=%b ov=%b exp=0,0",
                     busy2, ov2);
        end
    endtask

    task automatic test_rounding();
        logic signed [7:0] exp_d[4];
        exp_d = '{8'sd3, -8'sd2, 8'sd4, -8'sd3};
        drain2({-32'sd7, 32'sd7, -32'sd5, 32'sd5}, 16'd1, 6'd1, 8'd0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (n2 <= i || q2_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL round_el%0d got=%0d exp=%0d n=%0d",
                         i, q2_d[i], exp_d[i], n2);
            end
        end
        exp_d = '{8'sd1, -8'sd1, 8'sd0, 8'sd0};
        drain2({32'sd0, 32'sd1000, 32'h8000_0000, 32'h7fff_ffff},
               16'd65535, 6'd63, 8'd0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (n2 <= i || q2_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL shift_clamp_el%0d got=%0d exp=%0d n=%0d",
                         i, q2_d[i], exp_d[i], n2);
            end
        end
    endtask

    task automatic test_saturate_zp();
        logic signed [7:0] exp_d[4];
`ifdef REQUANT_RELU_EN
        exp_d = '{8'sd10, 8'sd127, 8'sd10, 8'sd10};
`else
        exp_d = '{-8'sd128, 8'sd127, -8'sd128, 8'sd5};
`endif
        drain2({-32'sd5, -32'sd138, 32'sd120, -32'sd1000},
               16'd1, 6'd0, 8'd10);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (n2 <= i || q2_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL sat_zp_el%0d got=%0d exp=%0d n=%0d",
                         i, q2_d[i], exp_d[i], n2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [7:0] base_d[16];
        logic              base_l[16];
        logic signed [7:0] prev_d;
        logic              prev_l, stalled, seen;
        int n, k, stall_bad, stall_cnt;
        for (int i = 0; i < 16; i++) acc4[i*32 +: 32] = 32'(i * 100 - 700);
        mult4 = 16'd1; shift4 = 6'd2; zp4 = 8'd3;
        drain4();
        total++;
        if (n4 !== 16) begin
            bad++; $display("FAIL full_rate_count got=%0d exp=16", n4);
        end
        for (int i = 0; i < 16; i++) begin
            base_d[i] = q4_d[i]; base_l[i] = q4_l[i];
            total++;
            if (q4_d[i] !== ref_q(i * 100 - 700, 1, 2, 3)) begin
                bad++;
                $display("FAIL full_rate_el%0d got=%0d exp=%0d",
                         i, q4_d[i], ref_q(i * 100 - 700, 1, 2, 3));
            end
        end
        n = 0; k = 0; stalled = 1'b0; seen = 1'b0;
        stall_bad = 0; stall_cnt = 0;
        prev_d = '0; prev_l = 1'b0;
        tick(); start4 = 1'b1;
        tick(); start4 = 1'b0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            if (ov4) seen = 1'b1;
            if (!seen) rdy4 = 1'b1;
            else if (k < 4) rdy4 = (k == 0 || k == 3);
            else rdy4 = 1'($urandom_range(0, 1));
            if (seen) k++;
            if (ov4 && stalled) begin
                stall_cnt++;
                if (od4 !== prev_d || ol4 !== prev_l) stall_bad++;
            end
            if (ov4 && rdy4) begin
                q4_d[n] = od4; q4_l[n] = ol4; n++;
            end
            stalled = ov4 && !rdy4;
            prev_d = od4; prev_l = ol4;
            tick();
        end
        rdy4 = 1'b1;
        total++;
        if (stall_bad !== 0 || stall_cnt == 0) begin
            bad++;
            $display("FAIL stall_hold unstable=%0d of %0d exp=0 of >0",
                     stall_bad, stall_cnt);
        end
        total++;
        if (n !== 16) begin
            bad++; $display("FAIL bp_count got=%0d exp=16", n);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (q4_d[i] !== base_d[i] || q4_l[i] !== base_l[i] ||
                q4_l[i] !== (i == 15)) begin
                bad++;
                $display("FAIL bp_el%0d got=%0d/%b exp=%0d/%b",
                         i, q4_d[i], q4_l[i], base_d[i], (i == 15));
            end
        end
        tick(); tick();
    endtask

    task automatic test_abort();
        int n;
        logic done_seen;
        rdy4 = 1'b1; n = 0;
        tick(); start4 = 1'b1;
        tick(); start4 = 1'b0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (ov4) n++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ov4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0 || n !== 5) begin
            bad++;
            $display("FAIL abort ov=%b busy=%b done=%b n=%0d exp=0,0,0,5",
                     ov4, busy4, done4, n);
        end
        done_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done4 || ov4) done_seen = 1'b1;
            tick();
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++; $display("FAIL abort_quiet got=1 exp=0");
        end
        for (int i = 0; i < 16; i++) acc4[i*32 +: 32] = 32'(i * 40 + 1);
        mult4 = 16'd3; shift4 = 6'd3; zp4 = 8'hf6;
        drain4();
        total++;
        if (n4 !== 16) begin
            bad++; $display("FAIL restart_count got=%0d exp=16", n4);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (q4_d[i] !== ref_q(i * 40 + 1, 3, 3, -10)) begin
                bad++;
                $display("FAIL restart_el%0d got=%0d exp=%0d",
                         i, q4_d[i], ref_q(i * 40 + 1, 3, 3, -10));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing_2x2();
        test_rounding();
        test_saturate_zp();
        test_backpressure();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_requant_drain.md
ACC_REQUANT_DRAIN -- requirements
Module: acc_requant_drain

Interface
REQ-001 Parameter ROWS, default 4, array rows drained.
REQ-002 Parameter COLS, default 4, array columns drained.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset rst, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to snapshot and drain the array.
REQ-006 acc_flat  in  ROWS*COLS*32  signed PE results; element (r,c) at bits [(r*COLS+c)*32 +: 32].
REQ-007 mult  in  16  unsigned requant multiplier, sampled at start.
REQ-008 shift  in  6  right-shift amount, sampled at start.
REQ-009 zero_point  in  8  signed output offset, sampled at start.
REQ-010 accum_clear  out  1  one-cycle pulse driving the PE accum_reset inputs.
REQ-011 out_data  out  8  signed requantized element.
REQ-012 out_valid / out_ready  out / in  1 each  output handshake.
REQ-013 out_last  out  1  marks element (ROWS-1,COLS-1).
REQ-014 busy  out  1  high from start acceptance until done.
REQ-015 done  out  1  one-cycle pulse after last element transfers.

Function
REQ-016 States IDLE, CAPTURE, DRAIN, FINISH; IDLE->CAPTURE on start, CAPTURE->DRAIN next cycle, DRAIN->FINISH when last element transfers, FINISH->IDLE next cycle asserting done.
REQ-017 CAPTURE SHALL register all of acc_flat, mult, shift, zero_point and assert accum_clear in that same cycle.
REQ-018 start SHALL be ignored when not in IDLE; start and rst together SHALL yield reset.
REQ-019 Elements SHALL drain row-major, index 0..ROWS*COLS-1, one per transfer.
REQ-020 Pipeline: stage 1 registers p = acc * mult (49-bit signed); stage 2 registers rounded, offset, saturated result into out_data.
REQ-021 First out_valid SHALL assert 2 cycles after the CAPTURE cycle (start accepted at cycle 0 -> out_valid at cycle 3).
REQ-022 Transfer occurs when out_valid and out_ready both high; pipeline SHALL advance only if stage 2 is empty or transferring; no element dropped or duplicated under any ready pattern.
REQ-023 With out_valid high and out_ready low, out_data/out_last SHALL hold stable.
REQ-024 Rounding: shift=0 -> r=p; else r = (p + 2^(shift-1)) arithmetic-right-shifted by shift; shift>47 SHALL act as 47.
REQ-025 y = r + zero_point, saturated to [-128,127].
REQ-026 Full throughput: out_ready held high SHALL give one element per cycle.

Reset
REQ-027 On rst: state IDLE, busy/out_valid/out_last/done/accum_clear = 0, out_data = 0, index 0, pipeline valids cleared.
REQ-028 rst mid-drain SHALL abort immediately; no done pulse; snapshot discarded.

Configuration
REQ-029 Macro REQUANT_RELU_EN defined: lower saturation bound SHALL be max(zero_point,-128) (fused ReLU); undefined: lower bound -128.

Structure
REQ-030 Shared package holds accumulator width (32), output width (8), product width (49), max shift (47) and the state enumeration.
REQ-031 Sub-module requant_core (combinational round/offset/saturate) SHALL be instantiated between stage 1 and stage 2 registers.

Verification
REQ-032 2x2, acc={100,-100,1000,0}, mult=1, shift=2, zp=0, ready=1 -> out {25,-25,127,0}, out_last on 4th, done one cycle later.
REQ-033 acc=5, mult=1, shift=1 -> 3; acc=-5 -> -2 (round half up).
REQ-034 acc=-1000, mult=1, shift=0, zp=10 -> -128 without macro; 10 with REQUANT_RELU_EN.
REQ-035 out_ready toggling 1,0,0,1 random over 16 elements -> sequence identical to ready=1 run, outputs stable while stalled.
REQ-036 start at cycle 0 -> accum_clear pulse exactly at cycle 1, out_valid at cycle 3; second start while busy -> ignored.
REQ-037 rst asserted after 5 transfers -> next cycle out_valid=0, busy=0, no done; new start drains from element 0.
